// File: rtl/pipe_stall_regs.sv
// Front-end pipeline storage (PC, IF/ID, ID/EX) driven by hazard-unit stall/bubble controls,
// with ID-stage branch redirect, saturating stall/bubble statistics and a sticky stuck-stall watchdog.
// Latency: every output registered, 1 cycle. No backpressure; the caller's PCWrite/IF_ID_Write hold state.
module pipe_stall_regs #(
    parameter logic [31:0] PC_RESET    = 32'h0000_0000,
    parameter int          CTRL_W      = 12,
    parameter int          CNT_W       = 16,
    parameter int          STALL_LIMIT = 4
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              PCWrite,
    input  logic              IF_ID_Write,
    input  logic              ID_EX_FlushCtrl,
    input  logic              BranchTaken,
    input  logic [31:0]       BranchTarget,
    input  logic [31:0]       IF_Instruction,
    input  logic [CTRL_W-1:0] ID_Ctrl,
    input  logic [4:0]        ID_Rs,
    input  logic [4:0]        ID_Rt,
    input  logic [4:0]        ID_Rd,
    input  logic [31:0]       ID_ReadData1,
    input  logic [31:0]       ID_ReadData2,
    input  logic [31:0]       ID_Imm,
    output logic [31:0]       PC,
    output logic [31:0]       IF_ID_Instruction,
    output logic [31:0]       IF_ID_PCPlus4,
    output logic [CTRL_W-1:0] EX_Ctrl,
    output logic [4:0]        EX_Rs,
    output logic [4:0]        EX_Rt,
    output logic [4:0]        EX_Rd,
    output logic [31:0]       EX_ReadData1,
    output logic [31:0]       EX_ReadData2,
    output logic [31:0]       EX_Imm,
    output logic [31:0]       EX_PCPlus4,
    output logic [CNT_W-1:0]  StallCount,
    output logic [CNT_W-1:0]  BubbleCount,
    output logic              StallTimeout
);

    localparam int RUN_W = $clog2(STALL_LIMIT + 1);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(STALL_LIMIT);

    logic [31:0]       pc_q, pc_d;
    logic [31:0]       ifid_instr_q, ifid_instr_d;
    logic [31:0]       ifid_pcp4_q, ifid_pcp4_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [4:0]        ex_rs_q, ex_rs_d;
    logic [4:0]        ex_rt_q, ex_rt_d;
    logic [4:0]        ex_rd_q, ex_rd_d;
    logic [31:0]       ex_rd1_q, ex_rd1_d;
    logic [31:0]       ex_rd2_q, ex_rd2_d;
    logic [31:0]       ex_imm_q, ex_imm_d;
    logic [31:0]       ex_pcp4_q, ex_pcp4_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic              timeout_q, timeout_d;
    logic              redir;
    logic [31:0]       pc_plus4;

    always_comb begin
        // A branch sitting in a stalled ID stage must not redirect yet.
        redir    = BranchTaken & PCWrite;
        pc_plus4 = pc_q + 32'd4;

        pc_d = pc_q;
        if (redir) begin
            pc_d = BranchTarget;
        end else if (PCWrite) begin
            pc_d = pc_plus4;
        end

        ifid_instr_d = ifid_instr_q;
        ifid_pcp4_d  = ifid_pcp4_q;
        if (redir) begin
            ifid_instr_d = 32'd0;
            ifid_pcp4_d  = 32'd0;
        end else if (IF_ID_Write) begin
            ifid_instr_d = IF_Instruction;
            ifid_pcp4_d  = pc_plus4;
        end

        ex_ctrl_d = ID_EX_FlushCtrl ? '0 : ID_Ctrl;
        ex_rs_d   = ID_Rs;
        ex_rt_d   = ID_Rt;
        ex_rd_d   = ID_Rd;
        ex_rd1_d  = ID_ReadData1;
        ex_rd2_d  = ID_ReadData2;
        ex_imm_d  = ID_Imm;
        ex_pcp4_d = ifid_pcp4_q;

        stall_cnt_d = stall_cnt_q;
        if (!PCWrite && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        bubble_cnt_d = bubble_cnt_q;
        if (ID_EX_FlushCtrl && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end

        run_d = run_q;
        if (PCWrite) begin
            run_d = '0;
        end else if (run_q != RUN_LIMIT) begin
            run_d = run_q + RUN_W'(1);
        end

        // Trips on the stall cycle that brings the run up to the limit.
        timeout_d = timeout_q | (!PCWrite && (run_q >= (RUN_LIMIT - RUN_W'(1))));
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            pc_q         <= PC_RESET;
            ifid_instr_q <= '0;
            ifid_pcp4_q  <= '0;
            ex_ctrl_q    <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_rd_q      <= '0;
            ex_rd1_q     <= '0;
            ex_rd2_q     <= '0;
            ex_imm_q     <= '0;
            ex_pcp4_q    <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            run_q        <= '0;
            timeout_q    <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pcp4_q  <= ifid_pcp4_d;
            ex_ctrl_q    <= ex_ctrl_d;
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            ex_rd_q      <= ex_rd_d;
            ex_rd1_q     <= ex_rd1_d;
            ex_rd2_q     <= ex_rd2_d;
            ex_imm_q     <= ex_imm_d;
            ex_pcp4_q    <= ex_pcp4_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            run_q        <= run_d;
            timeout_q    <= timeout_d;
        end
    end

    assign PC                = pc_q;
    assign IF_ID_Instruction = ifid_instr_q;
    assign IF_ID_PCPlus4     = ifid_pcp4_q;
    assign EX_Ctrl           = ex_ctrl_q;
    assign EX_Rs             = ex_rs_q;
    assign EX_Rt             = ex_rt_q;
    assign EX_Rd             = ex_rd_q;
    assign EX_ReadData1      = ex_rd1_q;
    assign EX_ReadData2      = ex_rd2_q;
    assign EX_Imm            = ex_imm_q;
    assign EX_PCPlus4        = ex_pcp4_q;
    assign StallCount        = stall_cnt_q;
    assign BubbleCount       = bubble_cnt_q;
    assign StallTimeout      = timeout_q;

endmodule
